// File: rtl/sprite_palette_bank.sv
// Two-stage palette lookup: BANKS writable RGB palettes, frame-synchronised bank swap,
// transparency flag and a per-frame saturating fade applied to every channel.
module sprite_palette_bank #(
    parameter int                    IDX_W      = 4,
    parameter int                    CH_W       = 4,
    parameter int                    BANKS      = 4,
    parameter logic [IDX_W-1:0]      TRANSP_IDX = '0,
    parameter logic [3*CH_W-1:0]     RST_RGB    = 12'h99F,
    localparam int                   BW         = (BANKS > 1) ? $clog2(BANKS) : 1,
    localparam int                   ENTRIES    = 2 ** IDX_W
) (
    input  logic                Clk,
    input  logic                Reset_n,
    input  logic [IDX_W-1:0]    index,
    input  logic                index_valid,
    input  logic                frame_start,
    input  logic                swap_req,
    input  logic [BW-1:0]       swap_bank,
    input  logic [CH_W-1:0]     fade_in,
    input  logic                wr_en,
    input  logic [BW-1:0]       wr_bank,
    input  logic [IDX_W-1:0]    wr_idx,
    input  logic [3*CH_W-1:0]   wr_rgb,
    output logic [CH_W-1:0]     red,
    output logic [CH_W-1:0]     green,
    output logic [CH_W-1:0]     blue,
    output logic                transparent,
    output logic                out_valid,
    output logic [BW-1:0]       active_bank,
    output logic                swap_pending
);

    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] PENDING = 1'b1;

    // Channel minus fade, clamped at zero instead of wrapping.
    function automatic logic [CH_W-1:0] sat_sub(input logic [CH_W-1:0] ch,
                                                input logic [CH_W-1:0] amt);
        logic signed [CH_W:0] diff;
        diff = $signed({1'b0, ch}) - $signed({1'b0, amt});
        return (diff < 0) ? '0 : diff[CH_W-1:0];
    endfunction

    logic [3*CH_W-1:0] pal [BANKS][ENTRIES];

    logic [0:0]        state;
    logic [BW-1:0]     pend_bank;
    logic [CH_W-1:0]   fade;

    logic              vld_p1;
    logic [IDX_W-1:0]  idx_p1;
    logic [3*CH_W-1:0] rgb_p1;

    // Each entry is its own register so reset can restore the whole palette.
    for (genvar b = 0; b < BANKS; b++) begin : g_bank
        for (genvar e = 0; e < ENTRIES; e++) begin : g_entry
            always_ff @(posedge Clk or negedge Reset_n) begin
                if (!Reset_n) begin
                    pal[b][e] <= RST_RGB;
                end else if (wr_en && wr_bank == BW'(b) && wr_idx == IDX_W'(e)) begin
                    pal[b][e] <= wr_rgb;
                end
            end
        end
    end

    // Bank swap control: requests latch until the next frame_start.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state       <= IDLE;
            pend_bank   <= '0;
            active_bank <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (swap_req) begin
                        pend_bank <= swap_bank;
                        if (frame_start) begin
                            active_bank <= swap_bank;
                        end else begin
                            state <= PENDING;
                        end
                    end
                end
                PENDING: begin
                    if (swap_req) begin
                        pend_bank <= swap_bank;
                    end
                    if (frame_start) begin
                        active_bank <= swap_req ? swap_bank : pend_bank;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign swap_pending = (state == PENDING);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            fade <= '0;
        end else if (frame_start) begin
            fade <= fade_in;
        end
    end

    // Stage 1: capture index and read the bank active at this edge.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            vld_p1 <= 1'b0;
            idx_p1 <= '0;
            rgb_p1 <= '0;
        end else begin
            vld_p1 <= index_valid;
            idx_p1 <= index;
            rgb_p1 <= pal[active_bank][index];
        end
    end

    // Stage 2: fade and transparency; colour holds across invalid slots.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            red         <= '0;
            green       <= '0;
            blue        <= '0;
            transparent <= 1'b0;
            out_valid   <= 1'b0;
        end else begin
            out_valid <= vld_p1;
            if (vld_p1) begin
                red         <= sat_sub(rgb_p1[3*CH_W-1:2*CH_W], fade);
                green       <= sat_sub(rgb_p1[2*CH_W-1:CH_W], fade);
                blue        <= sat_sub(rgb_p1[CH_W-1:0], fade);
                transparent <= (idx_p1 == TRANSP_IDX);
            end
        end
    end

endmodule

// File: tb/tb_sprite_palette_bank.sv
// Directed plus randomized bench for sprite_palette_bank against a cycle-level reference model.
module tb_sprite_palette_bank;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic [3:0]  index;
    logic        index_valid;
    logic        frame_start;
    logic        swap_req;
    logic [1:0]  swap_bank;
    logic [3:0]  fade_in;
    logic        wr_en;
    logic [1:0]  wr_bank;
    logic [3:0]  wr_idx;
    logic [11:0] wr_rgb;
    logic [3:0]  red, green, blue;
    logic        transparent, out_valid, swap_pending;
    logic [1:0]  active_bank;

    sprite_palette_bank dut (
        .Clk(Clk), .Reset_n(Reset_n), .index(index), .index_valid(index_valid),
        .frame_start(frame_start), .swap_req(swap_req), .swap_bank(swap_bank),
        .fade_in(fade_in), .wr_en(wr_en), .wr_bank(wr_bank), .wr_idx(wr_idx),
        .wr_rgb(wr_rgb), .red(red), .green(green), .blue(blue),
        .transparent(transparent), .out_valid(out_valid),
        .active_bank(active_bank), .swap_pending(swap_pending)
    );

    always #5 Clk = ~Clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    logic [11:0] pal_m [4][16];
    logic [1:0]  act_m, pend_m;
    logic        pnd_m;
    logic [3:0]  fade_m;
    logic        vld1_m;
    logic [3:0]  idx1_m;
    logic [11:0] rgb1_m;
    logic [11:0] out_m;
    logic        tr_m, ov_m;

    function automatic logic [3:0] fsub(input logic [3:0] c, input logic [3:0] f);
        int r;
        r = int'(c) - int'(f);
        if (r < 0) r = 0;
        return 4'(r);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int b = 0; b < 4; b++)
            for (int e = 0; e < 16; e++)
                pal_m[b][e] = 12'h99F;
        act_m = 0; pend_m = 0; pnd_m = 0; fade_m = 0;
        vld1_m = 0; idx1_m = 0; rgb1_m = 0;
        out_m = 0; tr_m = 0; ov_m = 0;
    endtask

    // Apply one rising edge to the model using the inputs as currently driven.
    task automatic model_edge();
        ov_m = vld1_m;
        if (vld1_m) begin
            out_m = {fsub(rgb1_m[11:8], fade_m), fsub(rgb1_m[7:4], fade_m), fsub(rgb1_m[3:0], fade_m)};
            tr_m  = (idx1_m == 4'd0);
        end
        vld1_m = index_valid;
        idx1_m = index;
        rgb1_m = pal_m[act_m][index];
        if (wr_en) pal_m[wr_bank][wr_idx] = wr_rgb;
        if (frame_start) begin
            fade_m = fade_in;
            if (swap_req) act_m = swap_bank;
            else if (pnd_m) act_m = pend_m;
            pnd_m = 0;
        end else if (swap_req) begin
            pnd_m  = 1;
            pend_m = swap_bank;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".rgb"}, 32'({red, green, blue}), 32'(out_m));
        chk({tag, ".transparent"}, 32'(transparent), 32'(tr_m));
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(ov_m));
        chk({tag, ".active_bank"}, 32'(active_bank), 32'(act_m));
        chk({tag, ".swap_pending"}, 32'(swap_pending), 32'(pnd_m));
    endtask

    task automatic step(input string tag);
        @(posedge Clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic idle();
        index = 0; index_valid = 0; frame_start = 0; swap_req = 0; swap_bank = 0;
        fade_in = 0; wr_en = 0; wr_bank = 0; wr_idx = 0; wr_rgb = 0;
    endtask

    task automatic lookup(input logic [3:0] i);
        idle();
        index = i;
        index_valid = 1;
    endtask

    initial begin
        idle();
        Reset_n = 0;
        model_reset();
        #12;
        check_all("reset");
        chk("reset.rgb0", 32'({red, green, blue}), 32'h0);
        Reset_n = 1;
        @(posedge Clk); #1;

        // Basic lookup and hold
        lookup(4'd5); step("t1a");
        idle();       step("t1b");
        chk("t1.rgb", 32'({red, green, blue}), 32'h99F);
        chk("t1.valid", 32'(out_valid), 32'h1);
        chk("t1.transp", 32'(transparent), 32'h0);
        step("t1c");
        chk("t1.hold_valid", 32'(out_valid), 32'h0);
        chk("t1.hold_rgb", 32'({red, green, blue}), 32'h99F);

        // Write versus same-cycle lookup
        lookup(4'd3); wr_en = 1; wr_bank = 0; wr_idx = 3; wr_rgb = 12'h44F; step("t2a");
        lookup(4'd3); step("t2b");
        chk("t2.old", 32'({red, green, blue}), 32'h99F);
        idle(); step("t2c");
        chk("t2.new", 32'({red, green, blue}), 32'h44F);

        // Pending swap held until frame_start
        idle(); wr_en = 1; wr_bank = 1; wr_idx = 2; wr_rgb = 12'hFC7; step("t3a");
        lookup(4'd2); swap_req = 1; swap_bank = 1; step("t3b");
        chk("t3.pending", 32'(swap_pending), 32'h1);
        lookup(4'd2); step("t3c");
        chk("t3.old_bank_rgb", 32'({red, green, blue}), 32'h99F);
        idle(); step("t3d");
        idle(); frame_start = 1; step("t3e");
        chk("t3.active", 32'(active_bank), 32'h1);
        chk("t3.cleared", 32'(swap_pending), 32'h0);
        lookup(4'd2); step("t3f");
        idle(); step("t3g");
        chk("t3.new_bank_rgb", 32'({red, green, blue}), 32'hFC7);

        // Last request wins; immediate swap with frame_start
        idle(); swap_req = 1; swap_bank = 2; step("t4a");
        idle(); swap_req = 1; swap_bank = 3; step("t4b");
        idle(); frame_start = 1; step("t4c");
        chk("t4.last_wins", 32'(active_bank), 32'h3);
        idle(); swap_req = 1; swap_bank = 1; frame_start = 1; step("t4d");
        chk("t4.immediate", 32'(active_bank), 32'h1);
        chk("t4.no_pending", 32'(swap_pending), 32'h0);

        // Fade with saturation
        idle(); frame_start = 1; fade_in = 4'h4; step("t5a");
        lookup(4'd2); step("t5b");
        idle(); step("t5c");
        chk("t5.fade4", 32'({red, green, blue}), 32'hB83);
        idle(); frame_start = 1; fade_in = 4'hA; step("t5d");
        lookup(4'd2); step("t5e");
        idle(); step("t5f");
        chk("t5.fadeA_sat", 32'({red, green, blue}), 32'h520);
        lookup(4'd2); fade_in = 4'h0; step("t5g");
        idle(); step("t5h");
        chk("t5.no_load", 32'({red, green, blue}), 32'h520);

        // Transparent index
        lookup(4'd0); step("t6a");
        idle(); step("t6b");
        chk("t6.transp", 32'(transparent), 32'h1);

        // Reset mid-stream
        lookup(4'd7); step("t7a");
        #2 Reset_n = 0;
        #1;
        model_reset();
        check_all("t7.rst");
        chk("t7.rst_valid", 32'(out_valid), 32'h0);
        #1 Reset_n = 1;
        lookup(4'd3); step("t7b");
        idle(); step("t7c");
        chk("t7.restored", 32'({red, green, blue}), 32'h99F);

        // Randomized traffic
        for (int cyc = 0; cyc < 600; cyc++) begin
            index       = 4'($urandom);
            index_valid = ($urandom_range(0, 3) != 0);
            frame_start = (cyc % 23 == 0);
            swap_req    = ($urandom_range(0, 7) == 0);
            swap_bank   = 2'($urandom);
            fade_in     = 4'($urandom);
            wr_en       = ($urandom_range(0, 2) == 0);
            wr_bank     = 2'($urandom);
            wr_idx      = 4'($urandom);
            wr_rgb      = 12'($urandom);
            step("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sprite_palette_bank.md
Name: sprite_palette_bank

Overview:
Parametrised, pipelined colour-palette lookup for sprite and background pixel paths, feeding the VGA colour mapper. Holds BANKS writable palettes of 2^IDX_W entries of 3×CH_W RGB. Adds frame-synchronised palette swapping (e.g. power-up or damage recolour), a transparency flag and a per-frame fade level. Lookup latency is fixed at 2 cycles.

Parameters:
IDX_W, 4, pixel index width; entries per bank = 2^IDX_W
CH_W, 4, bits per colour channel
BANKS, 4, number of palette banks (power of 2, ≥2)
TRANSP_IDX, 0, index reported as transparent
RST_RGB, 12'h99F, reset contents of every entry ({R,G,B}, 3×CH_W bits)

Ports:
Clk  in  1  system clock, all logic on rising edge
Reset_n  in  1  asynchronous active-low reset
index  in  IDX_W  pixel palette index
index_valid  in  1  index is a real pixel this cycle
frame_start  in  1  one-cycle pulse at start of vertical blank
swap_req  in  1  request bank change to swap_bank
swap_bank  in  log2(BANKS)  requested bank
fade_in  in  CH_W  requested fade amount, sampled at frame_start
wr_en  in  1  palette write strobe
wr_bank  in  log2(BANKS)  write bank
wr_idx  in  IDX_W  write entry
wr_rgb  in  3*CH_W  write data {R,G,B}
red, green, blue  out  CH_W each  faded colour
transparent  out  1  pixel index equals TRANSP_IDX
out_valid  out  1  outputs correspond to a valid index
active_bank  out  log2(BANKS)  bank used for lookups
swap_pending  out  1  swap accepted, not yet applied

Behaviour:
- Reset (async assert, sync deassert handled upstream): every entry of every bank = RST_RGB; active_bank=0; pending bank=0; swap_pending=0; fade=0; pipeline valids=0; red/green/blue = 0; transparent=0; out_valid=0.
- Stage 1 (cycle N+1): register index, index_valid, lookup from active_bank.
- Stage 2 (cycle N+2): channel_out = max(channel − fade, 0) per channel (saturating, no wrap); transparent = (stored index == TRANSP_IDX); out_valid = stage-1 valid.
- When stage-1 valid=0: red/green/blue/transparent hold their previous values; out_valid=0.
- Writes: wr_en writes wr_rgb to [wr_bank][wr_idx] at the clock edge; visible to lookups issued the following cycle. Lookup of the same entry in the write cycle returns the old value. Writes to any bank, including the active one, are allowed at any time.
- Swap state machine, states IDLE / PENDING:
  IDLE: swap_req=1 → latch swap_bank, swap_pending=1, go PENDING; if frame_start is also high that cycle, apply immediately (active_bank ← swap_bank, stay IDLE, swap_pending stays 0).
  PENDING: swap_req=1 overwrites latched bank (last request wins); frame_start=1 → active_bank ← latched (or simultaneous new swap_bank), swap_pending=0, go IDLE.
- active_bank changes only at frame_start, never mid-frame; lookups in flight when it changes complete in the stage where the bank was read (stage 1 uses bank at the time of its edge).
- Fade register loads fade_in only on frame_start; fade_in ignored otherwise.
- Reset mid-operation: all state to reset values immediately, palette contents included; pending swap discarded.
- Swapping to the already-active bank is legal and clears swap_pending at frame_start.

Test Plan:
- Reset release, index=5 valid for 1 cycle → 2 cycles later out_valid=1, RGB=9/9/F, transparent=0; idle cycles after → out_valid=0, RGB holds.
- Write bank0 idx3=0x44F, same-cycle lookup idx3 → returns 0x99F; lookup next cycle → 0x44F two cycles later.
- Write bank1 idx2=0xFC7, swap_req to bank1 mid-frame → swap_pending=1, lookups of idx2 still 0x99F; after frame_start pulse active_bank=1, swap_pending=0, idx2 → 0xFC7.
- swap_req bank2 then bank3 before frame_start → active_bank=3; swap_req and frame_start in same cycle → applied that edge, swap_pending never 1.
- fade_in=4 with frame_start, lookup 0xFC7 → 0xB83; fade_in=0xA → 0x520 (saturation, blue 7−A→0); fade_in changes without frame_start → no effect.
- index=TRANSP_IDX(0) valid → transparent=1 with colour of entry 0; assert Reset_n=0 mid-stream → outputs 0, out_valid=0, written entries back to 0x99F, active_bank=0.
